div_ctrl: RTL and testbench

DIV_CTRL -- requirements
Module: div_ctrl

---
 rtl/div_ctrl_pkg.sv | 22 ++
 rtl/div_ctrl_step.sv | 33 +++
 rtl/div_ctrl.sv | 137 +++++++++++++
 tb/tb_div_ctrl.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/div_ctrl_pkg.sv
// Shared constants and types for the iterative divider: bus width, FSM encoding,
// counter sizing and the divide-by-zero quotient fill.
package div_ctrl_pkg;

  localparam int unsigned DataBusWidth = 32;

  // Every quotient bit takes this value on a divide by zero
  localparam logic DivZeroQuotFill = 1'b1;

  typedef enum logic [1:0] {
    StIdle    = 2'd0,
    StDivZero = 2'd1,
    StBusy    = 2'd2,
    StDone    = 2'd3
  } div_state_e;

  // Iteration counter must be able to hold WIDTH itself
  function automatic int unsigned cnt_width(int unsigned w);
    return $clog2(w) + 1;
  endfunction

endpackage

// File: rtl/div_ctrl_step.sv
// One restoring shift-subtract step: shifts the next dividend bit into the partial
// remainder and subtracts the divisor when it fits.
module div_step
  import div_ctrl_pkg::*;
#(
  parameter int unsigned WIDTH = DataBusWidth
) (
  input  logic [WIDTH-1:0] rem_i,
  input  logic [WIDTH-1:0] divisor_i,
  input  logic             bit_i,
  output logic [WIDTH-1:0] rem_o,
  output logic             q_o
);

  logic [WIDTH:0] shifted;
  logic [WIDTH:0] diff;
  logic           unused_diff_msb;

  assign shifted         = {rem_i, bit_i};
  assign diff            = shifted - {1'b0, divisor_i};
  // rem_i < divisor_i always holds, so a successful subtraction fits in WIDTH bits
  assign unused_diff_msb = diff[WIDTH];

  always_comb begin
    q_o   = 1'b0;
    rem_o = shifted[WIDTH-1:0];
    if (shifted >= {1'b0, divisor_i}) begin
      q_o   = 1'b1;
      rem_o = diff[WIDTH-1:0];
    end
  end

endmodule

// File: rtl/div_ctrl.sv
// Multi-cycle signed/unsigned divider controller: FSM, iteration counter,
// operand latches and sign fix-up around a single combinational div_step.
module div_ctrl
  import div_ctrl_pkg::*;
#(
  parameter int unsigned WIDTH = DataBusWidth
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               annul,
  input  logic               signed_div,
  input  logic [WIDTH-1:0]   operand_1,
  input  logic [WIDTH-1:0]   operand_2,
  output logic [2*WIDTH-1:0] result,
  output logic               ready,
  output logic               stall_req
);

  localparam int unsigned    CntW     = cnt_width(WIDTH);
  localparam logic [CntW-1:0] LastStep = CntW'(WIDTH - 1);

  div_state_e         state_q, state_d;
  logic [CntW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0]   dividend_q, dividend_d;
  logic [WIDTH-1:0]   divisor_q, divisor_d;
  logic [WIDTH-1:0]   rem_q, rem_d;
  logic               neg_quot_q, neg_quot_d;
  logic               neg_rem_q, neg_rem_d;
  logic [2*WIDTH-1:0] result_q, result_d;

  logic [WIDTH-1:0]   step_rem;
  logic               step_q;
  logic [WIDTH-1:0]   quot_u;
  logic [WIDTH-1:0]   quot_fix;
  logic [WIDTH-1:0]   rem_fix;
  logic [WIDTH-1:0]   abs_op1;
  logic [WIDTH-1:0]   abs_op2;

  div_step #(
    .WIDTH(WIDTH)
  ) u_div_step (
    .rem_i    (rem_q),
    .divisor_i(divisor_q),
    .bit_i    (dividend_q[WIDTH-1]),
    .rem_o    (step_rem),
    .q_o      (step_q)
  );

  // Quotient bits shift into the dividend register as dividend bits shift out
  assign quot_u   = {dividend_q[WIDTH-2:0], step_q};
  assign quot_fix = neg_quot_q ? -quot_u : quot_u;
  assign rem_fix  = neg_rem_q ? -step_rem : step_rem;

  assign abs_op1 = (signed_div && operand_1[WIDTH-1]) ? -operand_1 : operand_1;
  assign abs_op2 = (signed_div && operand_2[WIDTH-1]) ? -operand_2 : operand_2;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    dividend_d = dividend_q;
    divisor_d  = divisor_q;
    rem_d      = rem_q;
    neg_quot_d = neg_quot_q;
    neg_rem_d  = neg_rem_q;
    result_d   = result_q;

    if (annul) begin
      state_d = StIdle;
    end else begin
      case (state_q)
        StIdle: begin
          if (start) begin
            if (operand_2 == '0) begin
              state_d    = StDivZero;
              dividend_d = operand_1;
            end else begin
              state_d    = StBusy;
              dividend_d = abs_op1;
              divisor_d  = abs_op2;
              rem_d      = '0;
              cnt_d      = '0;
              neg_quot_d = (operand_1[WIDTH-1] ^ operand_2[WIDTH-1]) & signed_div;
              neg_rem_d  = operand_1[WIDTH-1] & signed_div;
            end
          end
        end
        StDivZero: begin
          result_d = {dividend_q, {WIDTH{DivZeroQuotFill}}};
          state_d  = StDone;
        end
        StBusy: begin
          dividend_d = quot_u;
          rem_d      = step_rem;
          cnt_d      = cnt_q + 1'b1;
          if (cnt_q == LastStep) begin
            state_d  = StDone;
            result_d = {rem_fix, quot_fix};
          end
        end
        StDone: begin
          if (!start) begin
            state_d = StIdle;
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      dividend_q <= '0;
      divisor_q  <= '0;
      rem_q      <= '0;
      neg_quot_q <= 1'b0;
      neg_rem_q  <= 1'b0;
      result_q   <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      dividend_q <= dividend_d;
      divisor_q  <= divisor_d;
      rem_q      <= rem_d;
      neg_quot_q <= neg_quot_d;
      neg_rem_q  <= neg_rem_d;
      result_q   <= result_d;
    end
  end

  assign result    = result_q;
  assign ready     = (state_q == StDone);
  assign stall_req = start & ~annul & (state_q != StDone);

endmodule

// File: tb/tb_div_ctrl.sv
// Self-checking bench for div_ctrl: scoreboard of expected {remainder, quotient}
// values from a reference model, plus latency, stall, annul, hold and reset scenarios.
module tb_div_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        annul;
  logic        signed_div;
  logic [31:0] op1;
  logic [31:0] op2;
  logic [63:0] result;
  logic        ready;
  logic        stall_req;

  int          checks = 0;
  int          errors = 0;
  logic [63:0] exp_q[$];
  logic [63:0] last_res;

  always #5 clk = ~clk;

  div_ctrl #(
    .WIDTH(32)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .annul     (annul),
    .signed_div(signed_div),
    .operand_1 (op1),
    .operand_2 (op2),
    .result    (result),
    .ready     (ready),
    .stall_req (stall_req)
  );

  function automatic logic [63:0] model(input logic [31:0] a, input logic [31:0] b,
                                        input logic sgn);
    longint sa, sb, q, r;
    if (b == 32'd0) return {a, 32'hFFFF_FFFF};
    if (sgn) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      q  = sa / sb;
      r  = sa % sb;
      return {r[31:0], q[31:0]};
    end
    return {a % b, a / b};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one divide with start held; operands are scrambled after the first edge.
  task automatic do_div(input logic [31:0] a, input logic [31:0] b, input logic sgn,
                        input int lat, input int hold, input string name);
    int          n;
    logic [63:0] exp;
    op1        = a;
    op2        = b;
    signed_div = sgn;
    annul      = 1'b0;
    start      = 1'b1;
    exp_q.push_back(model(a, b, sgn));
    #1;
    checks++;
    if (stall_req !== 1'b1) $display("FAIL %s stall_T: got %b expected 1", name, stall_req);
    n = 0;
    while (n < 40) begin
      tick();
      n++;
      op1        = $urandom;
      op2        = $urandom;
      signed_div = 1'($urandom);
      if (ready === 1'b1) break;
      checks++;
      if (stall_req !== 1'b1) begin
        errors++;
        $display("FAIL %s stall_busy@%0d: got %b expected 1", name, n, stall_req);
      end
    end
    checks++;
    if (n !== lat) begin
      errors++;
      $display("FAIL %s latency: got %0d expected %0d", name, n, lat);
    end
    exp = exp_q.pop_front();
    checks++;
    if (result !== exp) begin
      errors++;
      $display("FAIL %s result: got %h expected %h", name, result, exp);
    end
    checks++;
    if (stall_req !== 1'b0) begin
      errors++;
      $display("FAIL %s stall_done: got %b expected 0", name, stall_req);
    end
    for (int i = 0; i < hold; i++) begin
      tick();
      checks++;
      if (ready !== 1'b1 || result !== exp || stall_req !== 1'b0) begin
        errors++;
        $display("FAIL %s hold%0d: got rdy=%b res=%h stall=%b expected rdy=1 res=%h stall=0",
                 name, i, ready, result, stall_req, exp);
      end
    end
    last_res = exp;
    start    = 1'b0;
    tick();
    checks++;
    if (ready !== 1'b0) begin
      errors++;
      $display("FAIL %s ready_drop: got %b expected 0", name, ready);
    end
  endtask

  task automatic test_reset();
    rst        = 1'b1;
    start      = 1'b1;
    annul      = 1'b0;
    signed_div = 1'b0;
    op1        = 32'd5;
    op2        = 32'd1;
    tick();
    tick();
    checks++;
    if (ready !== 1'b0 || result !== 64'd0) begin
      errors++;
      $display("FAIL reset_state: got rdy=%b res=%h expected rdy=0 res=0", ready, result);
    end
    checks++;
    if (stall_req !== 1'b1) begin
      errors++;
      $display("FAIL reset_stall_start: got %b expected 1", stall_req);
    end
    start = 1'b0;
    #1;
    checks++;
    if (stall_req !== 1'b0) begin
      errors++;
      $display("FAIL reset_stall_idle: got %b expected 0", stall_req);
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_spec_vectors();
    do_div(32'd100, 32'd7, 1'b0, 33, 0, "udiv_100_7");
    do_div(32'hFFFF_FFF9, 32'd2, 1'b1, 33, 0, "sdiv_m7_2");
    do_div(32'hFFFF_FFF9, 32'd2, 1'b0, 33, 0, "udiv_fff9_2");
    do_div(32'h0000_1234, 32'd0, 1'b0, 2, 0, "div_zero");
    do_div(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 33, 0, "sdiv_overflow");
    do_div(32'h8000_0000, 32'd0, 1'b1, 2, 0, "sdiv_zero");
    do_div(32'd5, 32'hFFFF_FFFD, 1'b1, 33, 0, "sdiv_5_m3");
  endtask

  task automatic test_random();
    logic [31:0] a, b;
    for (int i = 0; i < 8; i++) begin
      a = $urandom;
      b = (i == 3) ? 32'd0 : ($urandom >> (i * 3));
      do_div(a, b, 1'(i), (b == 32'd0) ? 2 : 33, 0, "random");
    end
  endtask

  task automatic test_annul();
    logic [63:0] prev;
    int          seen;
    prev       = last_res;
    op1        = 32'd100;
    op2        = 32'd7;
    signed_div = 1'b0;
    start      = 1'b1;
    repeat (10) tick();
    annul = 1'b1;
    #1;
    checks++;
    if (stall_req !== 1'b0) begin
      errors++;
      $display("FAIL annul_stall: got %b expected 0", stall_req);
    end
    tick();
    annul = 1'b0;
    start = 1'b0;
    seen  = 0;
    repeat (40) begin
      if (ready !== 1'b0) seen++;
      tick();
    end
    checks++;
    if (seen !== 0 || result !== prev) begin
      errors++;
      $display("FAIL annul_busy: got ready_cycles=%0d res=%h expected 0 res=%h",
               seen, result, prev);
    end
    do_div(32'd9, 32'd3, 1'b0, 33, 0, "after_annul");
    // annul in the same cycle as the final step
    prev  = last_res;
    op1   = 32'd100;
    op2   = 32'd7;
    start = 1'b1;
    repeat (32) tick();
    annul = 1'b1;
    tick();
    annul = 1'b0;
    start = 1'b0;
    checks++;
    if (ready !== 1'b0 || result !== prev) begin
      errors++;
      $display("FAIL annul_last_step: got rdy=%b res=%h expected rdy=0 res=%h",
               ready, result, prev);
    end
    tick();
  endtask

  task automatic test_hold_and_rst();
    do_div(32'd1000, 32'd33, 1'b0, 33, 3, "hold_done");
    op1   = 32'd100;
    op2   = 32'd7;
    start = 1'b1;
    repeat (5) tick();
    rst = 1'b1;
    tick();
    rst   = 1'b0;
    start = 1'b0;
    checks++;
    if (ready !== 1'b0 || result !== 64'd0) begin
      errors++;
      $display("FAIL rst_mid: got rdy=%b res=%h expected rdy=0 res=0", ready, result);
    end
    tick();
    do_div(32'd9, 32'd3, 1'b1, 33, 0, "after_rst");
  endtask

  initial begin
    test_reset();
    test_spec_vectors();
    test_random();
    test_annul();
    test_hold_and_rst();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

endmodule
